// File: rtl/rvx_pkg.sv
// Shared RVX10-P definitions: writeback result-source encoding, load funct3 codes
// and the layout of the MEM/WB pipeline register.
package rvx_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [1:0]  result_src;
        logic [2:0]  funct3;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
    } wb_reg_t;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Extracts a byte/halfword/word from an aligned memory word and sign- or
// zero-extends it according to the load funct3.
module load_extend
    import rvx_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        case (off)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            default: byte_s = word[31:24];
        endcase
        // Halfword loads ignore off[0]; misaligned halfwords are a separate unit's job.
        half_s = off[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_LB:   value = 32'(byte_s);
            F3_LBU:  value = {24'd0, byte_s};
            F3_LH:   value = 32'(half_s);
            F3_LHU:  value = {16'd0, half_s};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback mux of the RVX10-P core, with the
// 64-bit retired-instruction counter.
module mem_wb_stage
    import rvx_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_w,
    input  logic            flush_w,
    input  logic            valid_m,
    input  logic            reg_write_m,
    input  logic [1:0]      result_src_m,
    input  logic [2:0]      funct3_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] read_data_m,
    input  logic [XLEN-1:0] pc_plus4_m,
    input  logic [4:0]      rd_m,
    output logic            reg_write_w,
    output logic [4:0]      rd_w,
    output logic [XLEN-1:0] result_w,
    output logic            valid_w,
    output logic [63:0]     instret
);

    wb_reg_t     w_q;
    logic [31:0] load_val;

    always_ff @(posedge clk) begin
        if (reset || flush_w) begin
            w_q <= '0;
        end else if (!stall_w) begin
            w_q.valid      <= valid_m;
            w_q.reg_write  <= reg_write_m;
            w_q.result_src <= result_src_m;
            w_q.funct3     <= funct3_m;
            w_q.alu_result <= alu_result_m;
            w_q.read_data  <= read_data_m;
            w_q.pc_plus4   <= pc_plus4_m;
            w_q.rd         <= rd_m;
        end
    end

    // The instruction in W retires when it leaves: replaced by a new one or flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (w_q.valid && (flush_w || !stall_w)) begin
            instret <= instret + 64'd1;
        end
    end

    load_extend u_load_extend (
        .funct3 (w_q.funct3),
        .off    (w_q.alu_result[1:0]),
        .word   (w_q.read_data),
        .value  (load_val)
    );

    always_comb begin
        case (w_q.result_src)
            RES_MEM: result_w = load_val;
            RES_PC4: result_w = w_q.pc_plus4;
            default: result_w = w_q.alu_result;
        endcase
    end

    assign reg_write_w = w_q.valid & w_q.reg_write;
    assign rd_w        = w_q.rd;
    assign valid_w     = w_q.valid;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU/load/JAL writeback, stall/flush,
// reset priority and instret wrap.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall_w, flush_w, valid_m, reg_write_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
    logic [4:0]  rd_m;
    logic        reg_write_w, valid_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic [63:0] instret;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_w      (stall_w),
        .flush_w      (flush_w),
        .valid_m      (valid_m),
        .reg_write_m  (reg_write_m),
        .result_src_m (result_src_m),
        .funct3_m     (funct3_m),
        .alu_result_m (alu_result_m),
        .read_data_m  (read_data_m),
        .pc_plus4_m   (pc_plus4_m),
        .rd_m         (rd_m),
        .reg_write_w  (reg_write_w),
        .rd_w         (rd_w),
        .result_w     (result_w),
        .valid_w      (valid_w),
        .instret      (instret)
    );

    task automatic drive(input logic v, input logic rw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc4,
                         input logic [4:0] rd);
        valid_m = v; reg_write_m = rw; result_src_m = rs; funct3_m = f3;
        alu_result_m = alu; read_data_m = rdata; pc_plus4_m = pc4; rd_m = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_w = 1'b0; flush_w = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 3'b010, 32'hDEAD_BEEF, 32'h0, 32'h4, 5'd3);
        tick(); tick();
        total++;
        if ({reg_write_w, rd_w, result_w, valid_w} !== 39'd0 || instret !== 64'd0)
            $display("FAIL reset: rw=%b rd=%0d res=%h v=%b instret=%0d, want all 0",
                     reg_write_w, rd_w, result_w, valid_w, instret);
        else passed++;
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd5);
        tick();
        total++;
        if (reg_write_w !== 1'b1 || rd_w !== 5'd5 || result_w !== 32'h1234 ||
            valid_w !== 1'b1 || instret !== 64'd0)
            $display("FAIL alu_wb: rw=%b rd=%0d res=%h v=%b instret=%0d, want 1 5 00001234 1 0",
                     reg_write_w, rd_w, result_w, valid_w, instret);
        else passed++;
        drive(1'b0, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd6);
        tick();
        total++;
        if (instret !== 64'd1 || reg_write_w !== 1'b0)
            $display("FAIL alu_retire: instret=%0d rw=%b, want 1 0", instret, reg_write_w);
        else passed++;
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  off [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01};
        // W held a bubble before the first load, so counting starts at 1.
        logic [63:0] exp_cnt [5] = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 2'b01, f3[i], {30'h0000_4000, off[i]}, 32'h80FF_7F01,
                  32'h0, 5'(10 + i));
            tick();
            total++;
            if (result_w !== exp[i] || rd_w !== 5'(10 + i) || reg_write_w !== 1'b1 ||
                instret !== exp_cnt[i])
                $display("FAIL load_%0d: res=%h rd=%0d rw=%b instret=%0d, want %h %0d 1 %0d",
                         i, result_w, rd_w, reg_write_w, instret, exp[i], 10 + i, exp_cnt[i]);
            else passed++;
        end
    endtask

    task automatic test_jal();
        drive(1'b1, 1'b1, 2'b10, 3'b000, 32'h0000_0200, 32'h1111_1111, 32'h0000_0104, 5'd1);
        tick();
        total++;
        if (result_w !== 32'h104 || rd_w !== 5'd1 || reg_write_w !== 1'b1 || instret !== 64'd6)
            $display("FAIL jal_link: res=%h rd=%0d rw=%b instret=%0d, want 00000104 1 1 6",
                     result_w, rd_w, reg_write_w, instret);
        else passed++;
        drive(1'b1, 1'b0, 2'b11, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 5'd0);
        tick();
        total++;
        if (result_w !== 32'h55 || reg_write_w !== 1'b0 || valid_w !== 1'b1 || instret !== 64'd7)
            $display("FAIL src11_nowrite: res=%h rw=%b v=%b instret=%0d, want 00000055 0 1 7",
                     result_w, reg_write_w, valid_w, instret);
        else passed++;
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h0000_ABCD, 32'h0, 32'h0, 5'd7);
        tick();
        stall_w = 1'b1;
        drive(1'b1, 1'b1, 2'b10, 3'b000, 32'h9999_9999, 32'h0, 32'h7777_7777, 5'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (result_w !== 32'hABCD || rd_w !== 5'd7 || reg_write_w !== 1'b1 ||
                valid_w !== 1'b1 || instret !== 64'd8)
                $display("FAIL stall_%0d: res=%h rd=%0d rw=%b v=%b instret=%0d, want 0000abcd 7 1 1 8",
                         i, result_w, rd_w, reg_write_w, valid_w, instret);
            else passed++;
        end
        flush_w = 1'b1;
        tick();
        total++;
        if (valid_w !== 1'b0 || reg_write_w !== 1'b0 || instret !== 64'd9)
            $display("FAIL stall_flush: v=%b rw=%b instret=%0d, want 0 0 9",
                     valid_w, reg_write_w, instret);
        else passed++;
        stall_w = 1'b0; flush_w = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        total++;
        if (instret !== 64'd9)
            $display("FAIL bubble_no_count: instret=%0d, want 9", instret);
        else passed++;
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h0, 5'd12);
        tick();
        stall_w = 1'b1; flush_w = 1'b1; reset = 1'b1;
        tick();
        total++;
        if ({reg_write_w, rd_w, result_w, valid_w} !== 39'd0 || instret !== 64'd0)
            $display("FAIL reset_priority: rw=%b rd=%0d res=%h v=%b instret=%0d, want all 0",
                     reg_write_w, rd_w, result_w, valid_w, instret);
        else passed++;
        stall_w = 1'b0; flush_w = 1'b0; reset = 1'b0;
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h0000_0001, 32'h0, 32'h0, 5'd2);
        dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        total++;
        if (instret !== 64'hFFFF_FFFF_FFFF_FFFF || valid_w !== 1'b1)
            $display("FAIL wrap_preload: instret=%h v=%b, want ffffffffffffffff 1", instret, valid_w);
        else passed++;
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        total++;
        if (instret !== 64'd0)
            $display("FAIL wrap: instret=%h, want 0", instret);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_jal();
        test_stall_flush();
        test_reset_priority();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback stage of the RVX10-P five-stage core. It captures the retiring instruction's results from the Memory stage, selects and sign/zero-extends the writeback value, and drives the register-file write port (write enable, address, data). It also provides the writeback result to the forwarding path and keeps a 64-bit retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_w  in  1  hold the W register contents.
- flush_w  in  1  load a bubble into W.
- valid_m  in  1  M-stage slot holds a real instruction.
- reg_write_m  in  1  instruction writes rd.
- result_src_m  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 ALU.
- funct3_m  in  3  load size/sign field.
- alu_result_m  in  32  ALU result / effective address.
- read_data_m  in  32  raw aligned word from data memory.
- pc_plus4_m  in  32  PC+4 of the instruction.
- rd_m  in  5  destination register.
- reg_write_w  out  1  register-file write enable (we3).
- rd_w  out  5  register-file write address (a3).
- result_w  out  32  register-file write data (wd3); also the forwarding source.
- valid_w  out  1  W slot holds a real instruction.
- instret  out  64  count of retired instructions.

## Operation
- W register fields: valid, reg_write, result_src, funct3, alu_result, read_data, pc_plus4, rd.
- Update priority on each rising edge: reset > flush_w > stall_w > normal load.
  - reset: all fields 0.
  - flush_w: valid=0, reg_write=0, other fields don't-care (implement as 0). Flush wins over stall.
  - stall_w: all fields hold.
  - Otherwise: capture all *_m inputs.
- reg_write_w = valid & reg_write. A bubble never writes.
- rd_w = registered rd. A write to x0 is passed through; the register file discards it.
- Load extraction uses byte offset off = alu_result[1:0] and read_data:
  - 000 lb: sign-extend byte off.
  - 100 lbu: zero-extend byte off.
  - 001 lh: sign-extend halfword off[1] (upper if 1); off[0] ignored.
  - 101 lhu: zero-extend that halfword.
  - 010 lw, and reserved 011/110/111: full word, offset ignored.
- result_w: mux on result_src; 01 selects the extracted load value.
- instret increments by 1 on a rising edge where valid=1 and the W contents are replaced (not stall_w, or flush_w). It wraps from 2^64-1 to 0. Reset clears it to 0.

## Timing
- Reset values: reg_write_w=0, rd_w=0, result_w=0, valid_w=0, instret=0.
- Latency: an M-stage instruction presented at rising edge N appears on the W outputs immediately after edge N.
- result_w, reg_write_w and rd_w are combinational from W registers only; there is no path from *_m inputs.
- These outputs are stable well before the following falling edge, where the register file writes. The ID stage then reads the new value at rising edge N+1, so no W-to-ID bypass is needed.
- During stall_w, the same write repeats at each falling edge. This is idempotent and permitted.
- If reset is asserted mid-stall or alongside flush_w, reset wins: all state is 0 after that edge.

## Structure
- Shared package rvx_pkg holds:
  - result-source enum RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10;
  - funct3 load constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- One combinational sub-module, load_extend (inputs funct3, off, word; output 32-bit value), is reused by any future misaligned-access unit.
- The instret counter stays inline.

## Test plan
- Reset: hold reset 2 cycles with valid_m=1 and reg_write_m=1 -> all outputs 0, instret=0.
- ALU writeback: valid_m=1, reg_write_m=1, result_src_m=00, alu_result_m=0x0000_1234, rd_m=5 -> next cycle reg_write_w=1, rd_w=5, result_w=0x1234; instret becomes 1 on the following edge.
- Loads with read_data_m=0x80FF_7F01:
  - lb off=3 -> 0xFFFF_FF80;
  - lbu off=1 -> 0x0000_007F;
  - lh off=2 -> 0xFFFF_80FF;
  - lhu off=0 -> 0x0000_7F01;
  - lw off=2 -> 0x80FF_7F01.
- JAL link: result_src_m=10, pc_plus4_m=0x0000_0104, rd_m=1 -> result_w=0x104, rd_w=1.
- Stall/flush: load an instruction, then stall_w=1 for 3 cycles -> outputs held, instret unchanged. Then stall_w=1 and flush_w=1 together -> valid_w=0, reg_write_w=0, instret +1.
- Counter wrap: force instret to 2^64-1, retire one instruction -> instret=0.
